// File: rtl/rx_fifo_pkg.sv
// Shared UART constants: default data width, FIFO geometry and entry layout.
// Entry layout is {stop_err, parity_err, data}; flag offsets are relative to the data width.
package rx_fifo_pkg;

  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_FIFO_DEPTH  = 16;
  localparam int unsigned DEF_FIFO_ADDR_W = 4;

  localparam int unsigned ENTRY_FLAG_W = 2;
  localparam int unsigned PAR_OFS_REL  = 0;
  localparam int unsigned STOP_OFS_REL = 1;

endpackage

// File: rtl/rx_fifo_mem.sv
// Register-array storage for rx_fifo entries.
// One synchronous write port and one asynchronous read port; contents are not reset.
module rx_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned W     = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_fifo.sv
// FWFT receive FIFO behind the UART Rx engine, with occupancy and sticky overflow.
// Optional RX_FIFO_ERR_FILTER_EN drops errored characters and flags err_drop_o.
module rx_fifo
  import rx_fifo_pkg::*;
#(
  parameter int unsigned MAX_UART_DATA_W = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int unsigned FIFO_ADDR_W     = DEF_FIFO_ADDR_W
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       rx_done_i,
  input  logic [MAX_UART_DATA_W-1:0] rx_data_i,
  input  logic                       rx_parity_err_i,
  input  logic                       rx_stop_err_i,
  input  logic                       rd_ready_i,
  output logic                       rd_valid_o,
  output logic [MAX_UART_DATA_W-1:0] rd_data_o,
  output logic                       rd_parity_err_o,
  output logic                       rd_stop_err_o,
  output logic [FIFO_ADDR_W:0]       fifo_count_o,
  output logic                       fifo_full_o,
  output logic                       fifo_empty_o,
  output logic                       overflow_o
`ifdef RX_FIFO_ERR_FILTER_EN
  ,
  output logic                       err_drop_o
`endif
);

  localparam int unsigned ENTRY_W  = MAX_UART_DATA_W + ENTRY_FLAG_W;
  localparam int unsigned PAR_OFS  = MAX_UART_DATA_W + PAR_OFS_REL;
  localparam int unsigned STOP_OFS = MAX_UART_DATA_W + STOP_OFS_REL;
  localparam logic [FIFO_ADDR_W:0] CNT_FULL = (FIFO_ADDR_W+1)'(FIFO_DEPTH);

  logic                   rx_done_q, rx_done_d;
  logic [FIFO_ADDR_W-1:0] wptr_q, wptr_d;
  logic [FIFO_ADDR_W-1:0] rptr_q, rptr_d;
  logic [FIFO_ADDR_W:0]   count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   push, keep, pop, wr_en;
  logic [ENTRY_W-1:0]     wr_entry, rd_entry;

  assign push = rx_done_i & ~rx_done_q;
`ifdef RX_FIFO_ERR_FILTER_EN
  logic err_drop_q, err_drop_d;
  assign keep = push & ~(rx_parity_err_i | rx_stop_err_i);
`else
  assign keep = push;
`endif

  assign fifo_empty_o = (count_q == '0);
  assign fifo_full_o  = (count_q == CNT_FULL);
  assign fifo_count_o = count_q;
  assign rd_valid_o   = ~fifo_empty_o;
  assign overflow_o   = overflow_q;

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign pop   = ~fifo_empty_o & rd_ready_i & ~clr_i;
  assign wr_en = keep & (~fifo_full_o | pop) & ~clr_i;

  assign wr_entry = {rx_stop_err_i, rx_parity_err_i, rx_data_i};

  always_comb begin
    rx_done_d  = rx_done_i;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr_i) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_en) wptr_d = wptr_q + 1'b1;
      if (pop)   rptr_d = rptr_q + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (keep & fifo_full_o & ~pop) overflow_d = 1'b1;
    end
  end

`ifdef RX_FIFO_ERR_FILTER_EN
  always_comb begin
    err_drop_d = err_drop_q;
    if (clr_i)                  err_drop_d = 1'b0;
    else if (push & ~keep)      err_drop_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_drop_q <= 1'b0;
    else         err_drop_q <= err_drop_d;
  end

  assign err_drop_o = err_drop_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_done_q  <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rx_done_q  <= rx_done_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  rx_fifo_mem #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_ADDR_W),
    .W     (ENTRY_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rptr_q),
    .rdata_o (rd_entry)
  );

  assign rd_data_o       = rd_entry[MAX_UART_DATA_W-1:0];
  assign rd_parity_err_o = rd_entry[PAR_OFS];
  assign rd_stop_err_o   = rd_entry[STOP_OFS];

endmodule

// File: tb/tb_rx_fifo.sv
// Randomized and directed bench for rx_fifo against a queue-based reference model.
// Build with RX_FIFO_ERR_FILTER_EN defined to cover the error filter.
module tb_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          rx_done;
  logic [DW-1:0] rx_data;
  logic          rx_par;
  logic          rx_stop;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_par;
  logic          rd_stop;
  logic [AW:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          overflow;
`ifdef RX_FIFO_ERR_FILTER_EN
  logic          err_drop;
`endif

  always #5 clk = ~clk;

  rx_fifo dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clr_i           (clr),
    .rx_done_i       (rx_done),
    .rx_data_i       (rx_data),
    .rx_parity_err_i (rx_par),
    .rx_stop_err_i   (rx_stop),
    .rd_ready_i      (rd_ready),
    .rd_valid_o      (rd_valid),
    .rd_data_o       (rd_data),
    .rd_parity_err_o (rd_par),
    .rd_stop_err_o   (rd_stop),
    .fifo_count_o    (fifo_count),
    .fifo_full_o     (fifo_full),
    .fifo_empty_o    (fifo_empty),
    .overflow_o      (overflow)
`ifdef RX_FIFO_ERR_FILTER_EN
    ,
    .err_drop_o      (err_drop)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: ordered list of stored characters plus sticky flags
  logic [DW+1:0] mq[$];
  bit            m_prev;
  bit            m_ovf;
  bit            m_errdrop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit push, pop, err;
    push = rx_done && !m_prev;
    m_prev = rx_done;
    if (!rst_n) begin
      mq.delete();
      m_prev = 0;
      m_ovf = 0;
      m_errdrop = 0;
    end else if (clr) begin
      mq.delete();
      m_ovf = 0;
      m_errdrop = 0;
    end else begin
      pop = (mq.size() > 0) && rd_ready;
      err = rx_par || rx_stop;
`ifdef RX_FIFO_ERR_FILTER_EN
      if (push && err) begin
        m_errdrop = 1;
        push = 0;
      end
`endif
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() >= DEPTH) m_ovf = 1;
        else mq.push_back({rx_stop, rx_par, rx_data});
      end
    end
  endtask

  task automatic check_all();
    chk("count", 32'(fifo_count), 32'(mq.size()));
    chk("empty", 32'(fifo_empty), 32'(mq.size() == 0));
    chk("full", 32'(fifo_full), 32'(mq.size() == DEPTH));
    chk("valid", 32'(rd_valid), 32'(mq.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef RX_FIFO_ERR_FILTER_EN
    chk("err_drop", 32'(err_drop), 32'(m_errdrop));
`endif
    if (mq.size() > 0) begin
      chk("head", 32'({rd_stop, rd_par, rd_data}), 32'(mq[0]));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic push_char(input logic [DW-1:0] d, input logic p, input logic s,
                           input logic rdy);
    rx_data  = d;
    rx_par   = p;
    rx_stop  = s;
    rx_done  = 1'b1;
    rd_ready = rdy;
    tick();
    rx_done  = 1'b0;
    rd_ready = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; rx_done = 1'b0; rx_data = '0;
    rx_par = 1'b0; rx_stop = 1'b0; rd_ready = 1'b0;
    m_prev = 0; m_ovf = 0; m_errdrop = 0;

    // Reset
    tick();
    tick();
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single long pulse stores exactly one character
    rx_data = 8'hA5;
    rx_done = 1'b1;
    tick();
    chk("single_cnt", 32'(fifo_count), 32'd1);
    chk("single_data", 32'(rd_data), 32'hA5);
    for (int i = 0; i < 15; i++) tick();
    chk("single_hold_cnt", 32'(fifo_count), 32'd1);
    rx_done = 1'b0;
    pop_one();
    chk("single_pop_empty", 32'(fifo_empty), 32'd1);

    // Fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) push_char(8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full", 32'(fifo_full), 32'd1);
    chk("fill_cnt", 32'(fifo_count), 32'd16);
    push_char(8'hFF, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_cnt", 32'(fifo_count), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 32'(rd_data), 32'(i));
      pop_one();
    end
    chk("drain_empty", 32'(fifo_empty), 32'd1);

    // Full with simultaneous push and pop
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_char(8'(i), 1'b0, 1'b0, 1'b0);
    push_char(8'h77, 1'b0, 1'b0, 1'b1);
    chk("pp_cnt", 32'(fifo_count), 32'd16);
    chk("pp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("pp_last", 32'(rd_data), 32'h77);
      pop_one();
    end

    // Wrap-around with single-entry occupancy
    for (int i = 0; i < 40; i++) begin
      push_char(8'($urandom), 1'b0, 1'b0, 1'b0);
      chk("wrap_le1", 32'(fifo_count <= 1), 32'd1);
      pop_one();
      chk("wrap_le1", 32'(fifo_count <= 1), 32'd1);
    end

    // Error filter and flush
    push_char(8'h3C, 1'b1, 1'b0, 1'b0);
`ifdef RX_FIFO_ERR_FILTER_EN
    chk("filt_cnt", 32'(fifo_count), 32'd0);
    chk("filt_drop", 32'(err_drop), 32'd1);
`else
    chk("filt_cnt", 32'(fifo_count), 32'd1);
    chk("filt_par", 32'(rd_par), 32'd1);
`endif
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_cnt", 32'(fifo_count), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rx_done  = ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
      rx_par   = ($urandom_range(0, 5) == 0);
      rx_stop  = ($urandom_range(0, 5) == 0);
      rd_ready = ($urandom_range(0, 3) == 0);
      clr      = ($urandom_range(0, 150) == 0);
      rst_n    = ($urandom_range(0, 400) != 0);
      tick();
    end
    rst_n = 1'b1;
    clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
